cp0_exception_unit: RTL and testbench
=====================================

# cp0_exception_unit

Coprocessor-0 register file and precise-exception controller sitting at the MEM stage. It consumes the `ExceptinPipeType`/`RegsWrType` bundles that the EXE/MEM pipeline register delivers, and chooses the highest-priority exception or ERET. In that same cycle it drives the pipeline flushes, the redirect PC and the gated write enables `MEM_RegsWrType_new` that feed MEM/WB. It also holds Status, Cause, EPC, BadVAddr, Count and Compare, accepts MTC0 writes from WB, and raises the pending-interrupt flag that ID tags onto instructions.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380, general exception entry PC
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, IE=0, EXL=0)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  async active-high reset
- MEM_ExceptType  in  9  ExceptinPipeType of the MEM-stage instruction
- MEM_RegsWrType  in  3  {RFWr,CP0Wr,HILOWr} of the MEM-stage instruction
- MEM_PC  in  32  byte PC of the MEM-stage instruction
- MEM_ALUOut  in  32  data address, used for BadVAddr on load/store address errors
- MEM_InDelaySlot  in  1  MEM instruction sits in a branch delay slot
- Ext_Int  in  6  hardware interrupt lines, level-sensitive
- WB_CP0Wr  in  1  MTC0 commit strobe (WB_RegsWrType.CP0Wr)
- WB_Dst  in  5  CP0 register number
- WB_OutB  in  32  MTC0 write data
- CP0_RdAddr  in  5  MFC0 register number
- CP0_RdData  out  32  MFC0 read data
- CP0_IntPending  out  1  interrupt to be tagged onto the ID instruction
- MEM_RegsWrType_new  out  3  gated write enables toward MEM/WB
- IFID_Flush, IDEXE_Flush, EXEMEM_Flush  out  1 each  pipeline flushes
- Exc_Redirect  out  1  PC must load Exc_NPC
- Exc_NPC  out  32  EXC_VECTOR or EPC

## Operation
- Registers (number: writable bits):
  - BadVAddr 8: read-only
  - Count 9: all bits
  - Compare 11: all bits
  - Status 12: IM[15:8], EXL[1], IE[0]; BEV[22] is fixed at 1
  - Cause 13: IP[9:8] only; read-only fields are BD[31], TI[30], IP[15:10], ExcCode[6:2]
  - EPC 14: all bits
  - Unlisted numbers read 0 and ignore writes.
- Cause.IP[15:10] is sampled from Ext_Int every cycle. IP[15] is additionally ORed with TI.
- CP0_IntPending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- Exception priority, high to low, with ExcCode:
  - Interrupt 0x00
  - WrongAddressinIF, AdEL 0x04; BadVAddr=MEM_PC
  - ReservedInstruction 0x0A
  - Overflow 0x0C
  - Syscall 0x08
  - Break 0x09
  - RdWrongAddressinMEM, AdEL 0x04; BadVAddr=MEM_ALUOut
  - WrWrongAddressinMEM, AdES 0x05; BadVAddr=MEM_ALUOut
- Exception taken:
  - Set EXL and ExcCode.
  - If EXL was 0: EPC = MEM_InDelaySlot ? MEM_PC-4 : MEM_PC, and BD = MEM_InDelaySlot. If EXL was 1, EPC and BD are unchanged.
  - Outputs: Exc_NPC=EXC_VECTOR, Exc_Redirect=1, all three flushes=1, MEM_RegsWrType_new=3'b000.
- ERET, only when no other bit is set: clear EXL; Exc_NPC=EPC; redirect, flushes and write gating are the same as for an exception.
- Otherwise MEM_RegsWrType_new = MEM_RegsWrType and all control outputs are 0.
- Count increments once every two clocks (internal toggle bit).
- When Count==Compare and the timer feature is enabled, set TI. TI is cleared by any Compare write.
- CP0_RdData is combinational. It bypasses WB_OutB when WB_CP0Wr=1 and WB_Dst==CP0_RdAddr, returning the masked-writable merge.

## Timing
- Control outputs are combinational from MEM inputs in the same cycle. Register updates occur at the next clk edge.
- Reset values:
  - Status=STATUS_RST; Cause, EPC, BadVAddr, Count, Compare = 0; toggle bit = 0.
  - All outputs are 0 except CP0_RdData, which reflects the register read.
- Same-cycle MTC0 and exception: MTC0 applies first, then the exception overrides EXL, ExcCode, BD, EPC and BadVAddr.
- Same-cycle MTC0 Count and increment: the write wins.
- Same-cycle Compare write and match: TI ends at 0.
- Ext_Int is visible in Cause.IP one cycle after it changes. CP0_IntPending follows Cause.IP combinationally.
- Reset mid-exception discards the pending update. No redirect is asserted after reset release until a new exception arrives.

## Configuration
- CP0_TIMER_INT_EN defined: the Count==Compare match sets TI, and TI feeds IP[15].
- CP0_TIMER_INT_EN undefined: TI is held 0 and IP[15]=Ext_Int[5] only. Count and Compare remain readable and writable.

## Test plan
- Overflow at MEM_PC=0x8000_0100, EXL=0 -> same cycle: Exc_NPC=0xBFC0_0380, flushes=1, RegsWrType_new=0. Next cycle: EPC=0x8000_0100, ExcCode=0x0C, EXL=1.
- Syscall with MEM_InDelaySlot=1, MEM_PC=0x8000_0204 -> EPC=0x8000_0200, BD=1.
- Load address error with ALUOut=0x1000_0003 and ReservedInstruction also set -> ExcCode=0x0A, BadVAddr unchanged. Repeat with only RdWrongAddressinMEM set -> ExcCode=0x04, BadVAddr=0x1000_0003.
- MTC0 EPC=0x8000_0040, then ERET -> Exc_NPC=0x8000_0040, EXL cleared next cycle.
- MTC0 Status=0x0000_8001 (IM7, IE) with Compare=4 and Count from 0 -> TI set about 8 cycles later, CP0_IntPending=1. A Compare write clears it.
- MTC0 Cause=0x0000_0300 with a same-cycle MFC0 of register 13 -> CP0_RdData shows IP[9:8]=2'b11.

Source files
------------

// File: rtl/cp0_exception_unit_if.sv
// rtl/cp0_exception_unit_if.sv - MEM-stage exception bundle between the pipeline and CP0
interface cp0_exception_unit_if;
    // ExceptType bits: [8] Interrupt, [7] WrongAddressinIF, [6] ReservedInstruction, [5] Overflow,
    // [4] Syscall, [3] Break, [2] RdWrongAddressinMEM, [1] WrWrongAddressinMEM, [0] ERET
    logic [8:0]  MEM_ExceptType;
    logic [2:0]  MEM_RegsWrType;
    logic [31:0] MEM_PC;
    logic [31:0] MEM_ALUOut;
    logic        MEM_InDelaySlot;
    logic [2:0]  MEM_RegsWrType_new;
    logic        IFID_Flush;
    logic        IDEXE_Flush;
    logic        EXEMEM_Flush;
    logic        Exc_Redirect;
    logic [31:0] Exc_NPC;

    modport master (
        output MEM_ExceptType, MEM_RegsWrType, MEM_PC, MEM_ALUOut, MEM_InDelaySlot,
        input  MEM_RegsWrType_new, IFID_Flush, IDEXE_Flush, EXEMEM_Flush, Exc_Redirect, Exc_NPC
    );

    modport slave (
        input  MEM_ExceptType, MEM_RegsWrType, MEM_PC, MEM_ALUOut, MEM_InDelaySlot,
        output MEM_RegsWrType_new, IFID_Flush, IDEXE_Flush, EXEMEM_Flush, Exc_Redirect, Exc_NPC
    );
endinterface

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - CP0 registers and precise-exception controller at MEM
// Optional timer interrupt (Count==Compare sets Cause.TI) enabled by defining CP0_TIMER_INT_EN.
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    cp0_exception_unit_if.slave  mem,
    input  logic [5:0]           Ext_Int,
    input  logic                 WB_CP0Wr,
    input  logic [4:0]           WB_Dst,
    input  logic [31:0]          WB_OutB,
    input  logic [4:0]           CP0_RdAddr,
    output logic [31:0]          CP0_RdData,
    output logic                 CP0_IntPending
);
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;

    logic [31:0] badvaddr, count, compare, status, epc;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exccode;
    logic        bd, ti, toggle;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    assign wr_count   = WB_CP0Wr && (WB_Dst == 5'd9);
    assign wr_compare = WB_CP0Wr && (WB_Dst == 5'd11);
    assign wr_status  = WB_CP0Wr && (WB_Dst == 5'd12);
    assign wr_cause   = WB_CP0Wr && (WB_Dst == 5'd13);
    assign wr_epc     = WB_CP0Wr && (WB_Dst == 5'd14);

    // Register values after the MTC0 merge; also serve as the MFC0 bypass path.
    logic [31:0] status_w, epc_w, count_w, compare_w;
    logic [1:0]  ip_sw_w;
    assign status_w  = wr_status ? ((status & ~STATUS_WMASK) | (WB_OutB & STATUS_WMASK) | STATUS_BEV)
                                 : status;
    assign epc_w     = wr_epc     ? WB_OutB : epc;
    assign count_w   = wr_count   ? WB_OutB : count;
    assign compare_w = wr_compare ? WB_OutB : compare;
    assign ip_sw_w   = wr_cause   ? WB_OutB[9:8] : ip_sw;

    logic timer_hit;
`ifdef CP0_TIMER_INT_EN
    assign timer_hit = (count == compare);
`else
    assign timer_hit = 1'b0;
`endif

    logic [7:0] cause_ip, cause_ip_rd;
    assign cause_ip    = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
    assign cause_ip_rd = {ip_hw[5] | ti, ip_hw[4:0], ip_sw_w};

    assign CP0_IntPending = status[0] & ~status[1] & |(cause_ip & status[15:8]);

    logic [8:0]  ex;
    logic [4:0]  exc_code;
    logic        exc_addr, exc_take, eret_take, redirect;
    logic [31:0] exc_bad;
    assign ex        = mem.MEM_ExceptType;
    assign exc_take  = |ex[8:1];
    assign eret_take = ex[0] & ~exc_take;
    assign redirect  = exc_take | eret_take;

    always_comb begin
        exc_code = 5'h00;
        exc_addr = 1'b0;
        exc_bad  = mem.MEM_PC;
        if (ex[8])      exc_code = 5'h00;
        else if (ex[7]) begin exc_code = 5'h04; exc_addr = 1'b1; exc_bad = mem.MEM_PC; end
        else if (ex[6]) exc_code = 5'h0A;
        else if (ex[5]) exc_code = 5'h0C;
        else if (ex[4]) exc_code = 5'h08;
        else if (ex[3]) exc_code = 5'h09;
        else if (ex[2]) begin exc_code = 5'h04; exc_addr = 1'b1; exc_bad = mem.MEM_ALUOut; end
        else if (ex[1]) begin exc_code = 5'h05; exc_addr = 1'b1; exc_bad = mem.MEM_ALUOut; end
    end

    assign mem.Exc_Redirect       = redirect;
    assign mem.IFID_Flush         = redirect;
    assign mem.IDEXE_Flush        = redirect;
    assign mem.EXEMEM_Flush       = redirect;
    assign mem.Exc_NPC            = exc_take ? EXC_VECTOR : (eret_take ? epc : 32'h0);
    assign mem.MEM_RegsWrType_new = redirect ? 3'b000 : mem.MEM_RegsWrType;

    always_comb begin
        CP0_RdData = 32'h0;
        case (CP0_RdAddr)
            5'd8:    CP0_RdData = badvaddr;
            5'd9:    CP0_RdData = count_w;
            5'd11:   CP0_RdData = compare_w;
            5'd12:   CP0_RdData = status_w;
            5'd13:   CP0_RdData = {bd, ti, 14'b0, cause_ip_rd, 1'b0, exccode, 2'b00};
            5'd14:   CP0_RdData = epc_w;
            default: CP0_RdData = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr <= 32'h0;
            count    <= 32'h0;
            compare  <= 32'h0;
            status   <= STATUS_RST;
            epc      <= 32'h0;
            ip_hw    <= 6'h0;
            ip_sw    <= 2'h0;
            exccode  <= 5'h0;
            bd       <= 1'b0;
            ti       <= 1'b0;
            toggle   <= 1'b0;
        end else begin
            toggle  <= ~toggle;
            ip_hw   <= Ext_Int;
            count   <= wr_count ? WB_OutB : count + {31'b0, toggle};
            compare <= compare_w;
            status  <= status_w;
            epc     <= epc_w;
            ip_sw   <= ip_sw_w;
            if (wr_compare)     ti <= 1'b0;
            else if (timer_hit) ti <= 1'b1;
            // Exception fields override a same-cycle MTC0 to the same registers.
            if (exc_take) begin
                status[1] <= 1'b1;
                exccode   <= exc_code;
                if (!status_w[1]) begin
                    epc <= mem.MEM_InDelaySlot ? mem.MEM_PC - 32'd4 : mem.MEM_PC;
                    bd  <= mem.MEM_InDelaySlot;
                end
                if (exc_addr) badvaddr <= exc_bad;
            end else if (eret_take) begin
                status[1] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb/tb_cp0_exception_unit.sv - randomized self-checking bench for cp0_exception_unit
module tb_cp0_exception_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  Ext_Int;
    logic        WB_CP0Wr;
    logic [4:0]  WB_Dst;
    logic [31:0] WB_OutB;
    logic [4:0]  CP0_RdAddr;
    logic [31:0] CP0_RdData;
    logic        CP0_IntPending;

    cp0_exception_unit_if mif();

    cp0_exception_unit dut (
        .clk(clk), .rst(rst), .mem(mif), .Ext_Int(Ext_Int),
        .WB_CP0Wr(WB_CP0Wr), .WB_Dst(WB_Dst), .WB_OutB(WB_OutB),
        .CP0_RdAddr(CP0_RdAddr), .CP0_RdData(CP0_RdData), .CP0_IntPending(CP0_IntPending)
    );

    always #10 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register contents plus an edge counter for Count's half rate.
    logic [31:0] m_st, m_epc, m_bva, m_cnt, m_cmp;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;
    logic [4:0]  m_exc;
    logic        m_bd, m_ti;
    int          m_edges;

    // Priority table, highest first: ExceptType bit = 8 - index.
    int prio_code [0:7] = '{0, 4, 10, 12, 8, 9, 4, 5};
    int prio_src  [0:7] = '{0, 1, 0, 0, 0, 0, 2, 2};

    function automatic int pick(input logic [8:0] e);
        for (int i = 0; i < 8; i++) if (e[8-i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] wmask(input logic [4:0] a);
        case (a)
            5'd9, 5'd11, 5'd14: return 32'hFFFF_FFFF;
            5'd12:              return 32'h0000_FF03;
            5'd13:              return 32'h0000_0300;
            default:            return 32'h0;
        endcase
    endfunction

    function automatic logic [7:0] m_ip();
        return {m_iphw[5] | m_ti, m_iphw[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_raw(input logic [4:0] a);
        case (a)
            5'd8:  return m_bva;
            5'd9:  return m_cnt;
            5'd11: return m_cmp;
            5'd12: return m_st;
            5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 32'h0040_0000; m_epc = 0; m_bva = 0; m_cnt = 0; m_cmp = 0;
        m_ipsw = 0; m_iphw = 0; m_exc = 0; m_bd = 0; m_ti = 0; m_edges = 0;
    endtask

    task automatic model_check();
        int          idx;
        logic        exc, eret, redir, intp;
        logic [31:0] npc, rd;
        idx   = pick(mif.MEM_ExceptType);
        exc   = (idx >= 0);
        eret  = !exc && mif.MEM_ExceptType[0];
        redir = exc || eret;
        npc   = exc ? 32'hBFC0_0380 : (eret ? m_epc : 32'h0);
        intp  = m_st[0] && !m_st[1] && ((m_ip() & m_st[15:8]) != 8'h0);
        rd    = m_raw(CP0_RdAddr);
        if (WB_CP0Wr && WB_Dst == CP0_RdAddr)
            rd = (rd & ~wmask(CP0_RdAddr)) | (WB_OutB & wmask(CP0_RdAddr));
        chk("redirect", 32'(mif.Exc_Redirect), 32'(redir));
        chk("flushes", {29'b0, mif.IFID_Flush, mif.IDEXE_Flush, mif.EXEMEM_Flush}, redir ? 32'd7 : 32'd0);
        chk("exc_npc", mif.Exc_NPC, npc);
        chk("regs_wr_new", 32'(mif.MEM_RegsWrType_new), redir ? 32'd0 : 32'(mif.MEM_RegsWrType));
        chk("int_pending", 32'(CP0_IntPending), 32'(intp));
        chk("rd_data", CP0_RdData, rd);
    endtask

    task automatic model_step();
        int          idx;
        logic        cnt_wr, cmp_wr, hit, tog;
        idx    = pick(mif.MEM_ExceptType);
        hit    = (m_cnt == m_cmp);
        tog    = (m_edges % 2) == 1;
        cnt_wr = 0;
        cmp_wr = 0;
        if (WB_CP0Wr) begin
            case (WB_Dst)
                5'd9:  begin m_cnt = WB_OutB; cnt_wr = 1; end
                5'd11: begin m_cmp = WB_OutB; cmp_wr = 1; end
                5'd12: m_st = (m_st & ~32'h0000_FF03) | (WB_OutB & 32'h0000_FF03);
                5'd13: m_ipsw = WB_OutB[9:8];
                5'd14: m_epc = WB_OutB;
                default: ;
            endcase
        end
        if (!cnt_wr && tog) m_cnt = m_cnt + 1;
`ifdef CP0_TIMER_INT_EN
        if (cmp_wr) m_ti = 0; else if (hit) m_ti = 1;
`else
        if (cmp_wr || hit) m_ti = 0;
`endif
        if (idx >= 0) begin
            if (!m_st[1]) begin
                m_epc = mif.MEM_InDelaySlot ? mif.MEM_PC - 4 : mif.MEM_PC;
                m_bd  = mif.MEM_InDelaySlot;
            end
            m_st[1] = 1'b1;
            m_exc   = 5'(prio_code[idx]);
            if (prio_src[idx] == 1) m_bva = mif.MEM_PC;
            if (prio_src[idx] == 2) m_bva = mif.MEM_ALUOut;
        end else if (mif.MEM_ExceptType[0]) begin
            m_st[1] = 1'b0;
        end
        m_iphw = Ext_Int;
        m_edges++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst === 1'b0) model_check();
            @(posedge clk);
            if (rst !== 1'b0) model_reset();
            else model_step();
        end
    end

    task automatic idle();
        mif.MEM_ExceptType = 9'h0; mif.MEM_RegsWrType = 3'b0; mif.MEM_PC = 32'h0;
        mif.MEM_ALUOut = 32'h0; mif.MEM_InDelaySlot = 1'b0;
        Ext_Int = 6'h0; WB_CP0Wr = 1'b0; WB_Dst = 5'h0; WB_OutB = 32'h0; CP0_RdAddr = 5'h0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        cyc(); idle();
        WB_CP0Wr = 1'b1; WB_Dst = r; WB_OutB = d;
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string name);
        CP0_RdAddr = a;
        #1;
        chk(name, CP0_RdData, exp);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        rd_chk(12, 32'h0040_0000, "rst_status");
        rd_chk(13, 32'h0, "rst_cause");
        rd_chk(9, 32'h0, "rst_count");
        rd_chk(11, 32'h0, "rst_compare");
        rd_chk(14, 32'h0, "rst_epc");
        chk("rst_redirect", 32'(mif.Exc_Redirect), 32'h0);
        chk("rst_intpend", 32'(CP0_IntPending), 32'h0);

        mtc0(11, 32'hFFFF_FFFF);

        cyc(); idle();
        mif.MEM_ExceptType = 9'h020; mif.MEM_PC = 32'h8000_0100; mif.MEM_RegsWrType = 3'b111;
        #1;
        chk("ov_npc", mif.Exc_NPC, 32'hBFC0_0380);
        chk("ov_flush", {29'b0, mif.IFID_Flush, mif.IDEXE_Flush, mif.EXEMEM_Flush}, 32'd7);
        chk("ov_regs_new", 32'(mif.MEM_RegsWrType_new), 32'd0);
        cyc(); idle(); #1;
        rd_chk(14, 32'h8000_0100, "ov_epc");
        rd_chk(13, 32'h0000_0030, "ov_cause");
        rd_chk(12, 32'h0040_0002, "ov_status");

        mtc0(12, 32'h0);
        cyc(); idle();
        mif.MEM_ExceptType = 9'h010; mif.MEM_InDelaySlot = 1'b1; mif.MEM_PC = 32'h8000_0204;
        cyc(); idle(); #1;
        rd_chk(14, 32'h8000_0200, "sys_epc");
        rd_chk(13, 32'h8000_0020, "sys_cause_bd");

        mtc0(12, 32'h0);
        cyc(); idle();
        mif.MEM_ExceptType = 9'h044; mif.MEM_ALUOut = 32'h1000_0003;
        cyc(); idle(); #1;
        rd_chk(13, 32'h0000_0028, "ri_cause");
        rd_chk(8, 32'h0, "ri_badvaddr");
        mtc0(12, 32'h0);
        cyc(); idle();
        mif.MEM_ExceptType = 9'h004; mif.MEM_ALUOut = 32'h1000_0003;
        cyc(); idle(); #1;
        rd_chk(13, 32'h0000_0010, "adel_cause");
        rd_chk(8, 32'h1000_0003, "adel_badvaddr");

        mtc0(14, 32'h8000_0040);
        cyc(); idle();
        mif.MEM_ExceptType = 9'h001;
        #1;
        chk("eret_npc", mif.Exc_NPC, 32'h8000_0040);
        chk("eret_redirect", 32'(mif.Exc_Redirect), 32'h1);
        cyc(); idle(); #1;
        rd_chk(12, 32'h0040_0000, "eret_status");

        mtc0(13, 32'h0000_0300);
        rd_chk(13, 32'h0000_0310, "cause_bypass");
        chk("cause_bypass_ip", 32'(CP0_RdData[9:8]), 32'h3);
        mtc0(12, 32'h0000_0301);
        cyc(); idle(); #1;
        chk("sw_int_pend", 32'(CP0_IntPending), 32'h1);
        mtc0(12, 32'h0);
        mtc0(13, 32'h0);

        mtc0(11, 32'h4);
        mtc0(9, 32'h0);
        mtc0(12, 32'h0000_8001);
        repeat (12) begin cyc(); idle(); end
        #1;
`ifdef CP0_TIMER_INT_EN
        chk("timer_pend", 32'(CP0_IntPending), 32'h1);
`else
        chk("timer_pend", 32'(CP0_IntPending), 32'h0);
`endif
        mtc0(11, 32'h0000_1000);
        cyc(); idle(); #1;
        chk("timer_clear", 32'(CP0_IntPending), 32'h0);

        for (int c = 0; c < 3000; c++) begin
            int r;
            cyc();
            rst = ($urandom_range(0, 299) == 0);
            r = $urandom_range(0, 9);
            case (r)
                6:       mif.MEM_ExceptType = 9'(1 << $urandom_range(1, 8));
                7:       mif.MEM_ExceptType = 9'($urandom);
                8:       mif.MEM_ExceptType = 9'h001;
                9:       mif.MEM_ExceptType = 9'($urandom_range(1, 15));
                default: mif.MEM_ExceptType = 9'h0;
            endcase
            mif.MEM_RegsWrType  = 3'($urandom);
            mif.MEM_PC          = $urandom & 32'hFFFF_FFFC;
            mif.MEM_ALUOut      = $urandom;
            mif.MEM_InDelaySlot = 1'($urandom);
            if ($urandom_range(0, 7) == 0) Ext_Int = 6'($urandom);
            WB_CP0Wr = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 6))
                0: WB_Dst = 5'd8;
                1: WB_Dst = 5'd9;
                2: WB_Dst = 5'd11;
                3: WB_Dst = 5'd12;
                4: WB_Dst = 5'd13;
                5: WB_Dst = 5'd14;
                default: WB_Dst = 5'($urandom);
            endcase
            WB_OutB = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            CP0_RdAddr = 5'($urandom_range(0, 15));
        end
        cyc(); rst = 1'b0; idle();
        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
